// File: rtl/adder_nibble_seq.sv
// rtl/adder_nibble_seq.sv - multi-cycle W-bit adder built from one 4-bit adder stage
//
// Adds two NIBBLES*4-bit operands one nibble per clock through a single
// 4-bit adder, carrying between nibbles in a register.
// Optional subtract mode is enabled by defining ADDER_NIBBLE_SEQ_SUB_EN.
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous active-high reset, dominant over start
//   start  - request, accepted in IDLE or DONE
//   sub    - (ADDER_NIBBLE_SEQ_SUB_EN only) subtract a-b, sampled with start
//   a, b   - operands, latched on the accepted start
//   busy   - high while nibbles are being processed
//   done   - one-cycle pulse, sum/cout/zero valid
//   sum    - result modulo 2^W, held until the next accepted start
//   cout   - carry out of the top nibble (NOT borrow when subtracting)
//   zero   - high when sum == 0
module adder_nibble_seq #(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
`ifdef ADDER_NIBBLE_SEQ_SUB_EN
  input  logic         sub,
`endif
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         zero
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state, state_n;
  logic [W-1:0]   op_a, op_b;
  logic [W-1:0]   sum_r, sum_next;
  logic           cout_r, zero_r;
  logic           carry;
  logic [IW-1:0]  idx;
  logic [3:0]     nib_a, nib_b;
  logic [4:0]     add_res;
  logic           accept;
  logic           last;
  logic           sub_sel;

  function automatic logic [4:0] adder_4bit(input logic [3:0] x,
                                            input logic [3:0] y,
                                            input logic       cin);
    return {1'b0, x} + {1'b0, y} + {4'b0000, cin};
  endfunction

`ifdef ADDER_NIBBLE_SEQ_SUB_EN
  assign sub_sel = sub;
`else
  assign sub_sel = 1'b0;
`endif

  assign accept = start && (state == S_IDLE || state == S_DONE);
  assign last   = (idx == IW'(NIBBLES - 1));

  // Select the active nibble, add it with the held carry, and splice the
  // result into a copy of the sum so the final zero test sees the new nibble.
  always_comb begin
    nib_a    = 4'h0;
    nib_b    = 4'h0;
    sum_next = sum_r;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IW'(i)) begin
        nib_a = op_a[i*4 +: 4];
        nib_b = op_b[i*4 +: 4];
      end
    end
    add_res = adder_4bit(nib_a, nib_b, carry);
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IW'(i)) begin
        sum_next[i*4 +: 4] = add_res[3:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_RUN;
      S_RUN:   if (last)  state_n = S_DONE;
      S_DONE:  state_n = start ? S_RUN : S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_a   <= '0;
      op_b   <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      zero_r <= 1'b0;
      carry  <= 1'b0;
      idx    <= '0;
    end else if (accept) begin
      // Subtraction is a + ~b + 1: invert b once here and seed the carry.
      op_a  <= a;
      op_b  <= sub_sel ? ~b : b;
      carry <= sub_sel;
      idx   <= '0;
    end else if (state == S_RUN) begin
      sum_r <= sum_next;
      carry <= add_res[4];
      idx   <= idx + IW'(1);
      if (last) begin
        cout_r <= add_res[4];
        zero_r <= (sum_next == '0);
      end
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);
  assign sum  = sum_r;
  assign cout = cout_r;
  assign zero = zero_r;

endmodule

// File: tb/tb_adder_nibble_seq.sv
// tb/tb_adder_nibble_seq.sv - self-checking bench for adder_nibble_seq
module tb_adder_nibble_seq;

  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout, zero;
  logic [W-1:0] sum;

  int n_checks = 0;
  int n_fail = 0;

  adder_nibble_seq #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
`ifdef ADDER_NIBBLE_SEQ_SUB_EN
    .sub   (sub),
`endif
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a started operation yields its whole-word result NIBBLES edges
  // after acceptance; requests are only taken when no operation is running.
  int           m_left;
  logic         m_done, m_cout, m_zero, m_hold;
  logic [W-1:0] m_sum;
  logic [W:0]   m_res;

  function automatic logic [W:0] ref_result(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic s);
    logic [W:0] r;
    if (s) r = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
    else   r = {1'b0, x} + {1'b0, y};
    return r;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_sum  <= '0;
      m_cout <= 1'b0;
      m_zero <= 1'b0;
      m_hold <= 1'b1;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        m_sum  <= m_res[W-1:0];
        m_cout <= m_res[W];
        m_zero <= (m_res[W-1:0] == '0);
        m_hold <= 1'b1;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        m_left <= NIBBLES;
        m_res  <= ref_result(a, b, sub);
        m_hold <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_left != 0));
    chk("done", 32'(done), 32'(m_done));
    if (m_hold) begin
      chk("sum", 32'(sum), 32'(m_sum));
      chk("cout", 32'(cout), 32'(m_cout));
      chk("zero", 32'(zero), 32'(m_zero));
    end
  end

  task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic ts, input logic [W-1:0] es, input logic ec,
                        input logic ez);
    int busy_cnt;
    bit got;
    @(negedge clk);
    a = ta; b = tb; sub = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cnt = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (done) got = 1'b1;
      else begin
        if (busy) busy_cnt++;
        @(negedge clk);
      end
    end
    if (!got) begin
      chk({nm, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({nm, "_busy_cycles"}, 32'(busy_cnt), 32'(NIBBLES));
      chk({nm, "_sum"}, 32'(sum), 32'(es));
      chk({nm, "_cout"}, 32'(cout), 32'(ec));
      chk({nm, "_zero"}, 32'(zero), 32'(ez));
      @(negedge clk);
      chk({nm, "_held_sum"}, 32'(sum), 32'(es));
      chk({nm, "_done_pulse"}, 32'(done), 32'd0);
    end
    sub = 1'b0;
  endtask

  initial begin
    int nd;
    int d0, d1;
    logic [W-1:0] s0, s1;

    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_sum", 32'(sum), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_done", 32'(done), 32'h0);

    run_op("basic", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
    run_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1);
    run_op("chain", 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0);

    // Start held high: ignored during RUN, re-accepted from DONE.
    nd = 0; d0 = 0; d1 = 0; s0 = '0; s1 = '0;
    @(negedge clk);
    a = 16'h0003; b = 16'h0005; start = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 2) a = 16'h0008;
      if (done) begin
        if (nd == 0) begin d0 = k; s0 = sum; end
        else if (nd == 1) begin d1 = k; s1 = sum; end
        nd++;
      end
    end
    start = 1'b0;
    chk("b2b_count", 32'(nd >= 2), 32'd1);
    chk("b2b_first", 32'(s0), 32'h0008);
    chk("b2b_second", 32'(s1), 32'h000D);
    chk("b2b_period", 32'(d1 - d0), 32'd5);
    repeat (8) @(negedge clk);

    // Reset on the second RUN cycle aborts the operation.
    a = 16'h8000; b = 16'h8000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    begin
      int seen = 0;
      for (int i = 0; i < 6; i++) begin
        if (done) seen++;
        @(negedge clk);
      end
      chk("abort_no_done", 32'(seen), 32'd0);
    end
    run_op("after_abort", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0);

`ifdef ADDER_NIBBLE_SEQ_SUB_EN
    run_op("sub_pos", 16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0);
    run_op("sub_neg", 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_eq", 16'hABCD, 16'hABCD, 1'b1, 16'h0000, 1'b1, 1'b1);
`endif

    // Random traffic: starts at any time, operands changing every cycle,
    // occasional resets; the reference model checks every cycle.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 80) == 0);
      start = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0: a = '1;
        1: a = '0;
        default: a = W'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0: b = '1;
        1: b = W'(1);
        default: b = W'($urandom);
      endcase
`ifdef ADDER_NIBBLE_SEQ_SUB_EN
      sub = $urandom_range(0, 1) == 1;
`endif
    end
    reset = 1'b0;
    start = 1'b0;
    repeat (NIBBLES + 4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
